// File: rtl/nios_dbg_pkg.sv
// Shared defaults and width helpers for the Nios II JTAG debug command bridge.
package nios_dbg_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int NUM_CHAN_DEF    = 4;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ACT_BIT_DEF     = 37;

  // Queued command layout at the default widths; IR sits above the data.
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] jdo;
  } cmd_t;

  function automatic int cmd_width(input int ir_w, input int sr_w);
    return ir_w + sr_w;
  endfunction

  // Occupancy counter needs to hold DEPTH itself, hence one extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// Show-ahead command FIFO with a registered head word read out of an inferred RAM.
module nios_dbg_cmd_fifo
  import nios_dbg_pkg::*;
#(
  parameter int W     = cmd_width(IR_W_DEF, SR_W_DEF),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr;
  logic [CW-1:0] count_reg, avail;
  logic          valid_reg, pop_en, push_en;
  logic [W-1:0]  head_reg;

  assign full    = (count_reg == CW'(DEPTH));
  assign pop_en  = pop & valid_reg;
  assign push_en = push & (~full | pop_en);
  assign rd_addr = pop_en ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  // Entries already in RAM before this edge; a same-edge write is only readable a cycle later.
  assign avail   = count_reg - CW'(pop_en);

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_en);
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_en);
      count_reg  <= count_reg + CW'(push_en) - CW'(pop_en);
      valid_reg  <= (avail != '0);
      head_reg   <= mem[rd_addr];
    end
  end

  assign valid = valid_reg;
  assign dout  = head_reg;

endmodule

// File: rtl/nios_jtag_debug_cmd_bridge.sv
// System-clock side of the JTAG debug path: strobe sync, command capture, queue and decode.
// Define NIOS_DBG_DROP_COUNT_EN to build the saturating dropped-command counter.
module nios_jtag_debug_cmd_bridge
  import nios_dbg_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int NUM_CHAN    = NUM_CHAN_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACT_BIT     = ACT_BIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic [IR_W-1:0]     ir_in,
  input  logic [SR_W-1:0]     sr,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [SR_W-1:0]     cmd_jdo,
  output logic [IR_W-1:0]     cmd_ir,
  output logic [NUM_CHAN-1:0] take_action,
  output logic [NUM_CHAN-1:0] take_no_action,
  output logic                bad_ir,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [15:0]         drop_count
);

  localparam int CMD_W = cmd_width(IR_W, SR_W);

  logic [SYNC_STAGES-1:0] udr_sync_reg, uir_sync_reg;
  logic                   udr_edge_reg, uir_edge_reg;
  logic                   udr_rise, uir_rise;
  logic [IR_W-1:0]        ir_reg, wr_ir;
  logic                   fifo_full, pop, drop, acc, overflow_reg;
  logic [CMD_W-1:0]       head;

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_reg <= '0;
      uir_sync_reg <= '0;
      udr_edge_reg <= 1'b0;
      uir_edge_reg <= 1'b0;
      ir_reg       <= '0;
    end else begin
      udr_sync_reg <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
      uir_sync_reg <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
      udr_edge_reg <= udr_sync_reg[SYNC_STAGES-1];
      uir_edge_reg <= uir_sync_reg[SYNC_STAGES-1];
      if (uir_rise) ir_reg <= ir_in;
    end
  end

  assign udr_rise = udr_sync_reg[SYNC_STAGES-1] & ~udr_edge_reg;
  assign uir_rise = uir_sync_reg[SYNC_STAGES-1] & ~uir_edge_reg;
  // A coincident update-IR must tag this command with the new IR.
  assign wr_ir    = uir_rise ? ir_in : ir_reg;

  assign pop  = cmd_valid & cmd_ready;
  assign drop = udr_rise & fifo_full & ~pop;

  nios_dbg_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (udr_rise),
    .din   ({wr_ir, sr}),
    .pop   (pop),
    .full  (fifo_full),
    .valid (cmd_valid),
    .dout  (head)
  );

  assign cmd_ir  = head[CMD_W-1:SR_W];
  assign cmd_jdo = head[SR_W-1:0];

  // Commands being flushed by reset never produce action pulses.
  assign acc    = pop & ~reset;
  assign bad_ir = acc & (32'(cmd_ir) >= 32'(NUM_CHAN));

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
    logic chan_hit;
    assign chan_hit           = acc & (cmd_ir == IR_W'(gi));
    assign take_action[gi]    = chan_hit & cmd_jdo[ACT_BIT];
    assign take_no_action[gi] = chan_hit & ~cmd_jdo[ACT_BIT];
  end

  always_ff @(posedge clk) begin
    if (reset)        overflow_reg <= 1'b0;
    else if (drop)    overflow_reg <= 1'b1;
    else if (ovf_clr) overflow_reg <= 1'b0;
  end
  assign overflow = overflow_reg;

`ifdef NIOS_DBG_DROP_COUNT_EN
  logic [15:0] drop_count_reg;
  always_ff @(posedge clk) begin
    if (reset)
      drop_count_reg <= '0;
    else if (ovf_clr)
      drop_count_reg <= {15'd0, drop};
    else if (drop && drop_count_reg != 16'hFFFF)
      drop_count_reg <= drop_count_reg + 16'd1;
  end
  assign drop_count = drop_count_reg;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_nios_jtag_debug_cmd_bridge.sv
// Directed bench for the JTAG debug command bridge (NUM_CHAN=3, DEPTH=4, SYNC_STAGES=2).
module tb_nios_jtag_debug_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset, vs_udr, vs_uir, cmd_ready, ovf_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, bad_ir, overflow;
  logic [37:0] cmd_jdo;
  logic [1:0]  cmd_ir;
  logic [2:0]  take_action, take_no_action;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NIOS_DBG_DROP_COUNT_EN
  localparam logic [15:0] DC_AFTER_DROP = 16'd1;
`else
  localparam logic [15:0] DC_AFTER_DROP = 16'd0;
`endif

  always #5 clk = ~clk;

  nios_jtag_debug_cmd_bridge #(
    .SR_W(38), .IR_W(2), .NUM_CHAN(3), .DEPTH(4), .SYNC_STAGES(2), .ACT_BIT(37)
  ) dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_jdo(cmd_jdo), .cmd_ir(cmd_ir),
    .take_action(take_action), .take_no_action(take_no_action), .bad_ir(bad_ir),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_count(drop_count)
  );

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] sr;
    logic [2:0]  ta;
    logic [2:0]  tna;
    logic        bad;
  } vec_t;
  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_uir(input logic [1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_udr(input logic [37:0] data);
    sr     = data;
    vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20 && !cmd_valid; k++) tick();
    check(name, 64'(cmd_valid), 64'd1);
  endtask

  // Hold cmd_ready for one cycle and check the combinational decode of the head.
  task automatic accept(input string name, input logic [2:0] ta, input logic [2:0] tna,
                        input logic bad);
    cmd_ready = 1'b1;
    #1;
    check({name, ".take_action"}, 64'(take_action), 64'(ta));
    check({name, ".take_no_action"}, 64'(take_no_action), 64'(tna));
    check({name, ".bad_ir"}, 64'(bad_ir), 64'(bad));
    tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0] = '{2'd1, 38'h20_0000_00AB, 3'b010, 3'b000, 1'b0};
    vecs[1] = '{2'd0, 38'h00_1234_5678, 3'b000, 3'b001, 1'b0};
    vecs[2] = '{2'd2, 38'h3F_FFFF_FFFF, 3'b100, 3'b000, 1'b0};
    vecs[3] = '{2'd3, 38'h1F_0000_0001, 3'b000, 3'b000, 1'b1};
    vecs[4] = '{2'd3, 38'h20_0000_0000, 3'b000, 3'b000, 1'b1};
    vecs[5] = '{2'd1, 38'h00_0000_0000, 3'b000, 3'b010, 1'b0};

    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("reset.cmd_valid", 64'(cmd_valid), 64'd0);
    check("reset.cmd_jdo", 64'(cmd_jdo), 64'd0);
    check("reset.cmd_ir", 64'(cmd_ir), 64'd0);
    check("reset.actions", 64'({take_action, take_no_action, bad_ir}), 64'd0);
    check("reset.overflow", 64'(overflow), 64'd0);
    check("reset.drop_count", 64'(drop_count), 64'd0);

    // Single command with latency measured from the first sampling edge of vs_udr.
    pulse_uir(2'd1);
    sr = 38'h20_0000_00AB;
    vs_udr = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cmd_valid) begin
        lat = k;
        break;
      end
    end
    check("single.latency", 64'(lat - 1), 64'd3);
    repeat (2) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    check("single.cmd_ir", 64'(cmd_ir), 64'd1);
    check("single.cmd_jdo", 64'(cmd_jdo), 64'h20_0000_00AB);
    accept("single", 3'b010, 3'b000, 1'b0);
    #1;
    check("single.pulse_width", 64'({take_action, take_no_action}), 64'd0);
    check("single.empty", 64'(cmd_valid), 64'd0);
    $display("single command ir=1 jdo=20000000ab delivered");

    for (int i = 0; i < 6; i++) begin
      pulse_uir(vecs[i].ir);
      pulse_udr(vecs[i].sr);
      wait_valid($sformatf("vec%0d.valid", i));
      check($sformatf("vec%0d.cmd_ir", i), 64'(cmd_ir), 64'(vecs[i].ir));
      check($sformatf("vec%0d.cmd_jdo", i), 64'(cmd_jdo), 64'(vecs[i].sr));
      accept($sformatf("vec%0d", i), vecs[i].ta, vecs[i].tna, vecs[i].bad);
      check($sformatf("vec%0d.popped", i), 64'(cmd_valid), 64'd0);
      $display("vector %0d ir=%0d sr=%0h applied", i, vecs[i].ir, vecs[i].sr);
    end

    // Back-pressure: five updates into a four-deep queue.
    pulse_uir(2'd0);
    for (int k = 1; k <= 5; k++) pulse_udr(38'(k));
    check("ovf.overflow", 64'(overflow), 64'd1);
    check("ovf.drop_count", 64'(drop_count), 64'(DC_AFTER_DROP));
    for (int k = 1; k <= 4; k++) begin
      wait_valid($sformatf("ovf.drain%0d.valid", k));
      check($sformatf("ovf.drain%0d.jdo", k), 64'(cmd_jdo), 64'(k));
      accept($sformatf("ovf.drain%0d", k), 3'b000, 3'b001, 1'b0);
    end
    tick();
    check("ovf.empty", 64'(cmd_valid), 64'd0);
    check("ovf.sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf.cleared", 64'(overflow), 64'd0);
    check("ovf.count_cleared", 64'(drop_count), 64'd0);
    $display("overflow sequence complete");

    // Full queue: the fifth push lands on the same edge as the pop of entry 1.
    for (int k = 1; k <= 4; k++) pulse_udr(38'(k));
    sr = 38'd5;
    vs_udr = 1'b1;
    tick();
    tick();
    cmd_ready = 1'b1;
    #1;
    check("fullpp.pop1_jdo", 64'(cmd_jdo), 64'd1);
    check("fullpp.pop1_tna", 64'(take_no_action), 64'b001);
    tick();
    cmd_ready = 1'b0;
    repeat (2) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    check("fullpp.overflow", 64'(overflow), 64'd0);
    check("fullpp.drop_count", 64'(drop_count), 64'd0);
    for (int k = 2; k <= 5; k++) begin
      wait_valid($sformatf("fullpp.drain%0d.valid", k));
      check($sformatf("fullpp.drain%0d.jdo", k), 64'(cmd_jdo), 64'(k));
      accept($sformatf("fullpp.drain%0d", k), 3'b000, 3'b001, 1'b0);
    end
    tick();
    check("fullpp.empty", 64'(cmd_valid), 64'd0);
    $display("full push/pop sequence complete");

    // Reset with three commands queued: flushed silently.
    pulse_uir(2'd1);
    for (int k = 0; k < 3; k++) pulse_udr(38'h20_0000_0000 | 38'(k));
    check("rst.queued", 64'(cmd_valid), 64'd1);
    reset = 1'b1;
    cmd_ready = 1'b1;
    #1;
    check("rst.no_pulse", 64'({take_action, take_no_action, bad_ir}), 64'd0);
    tick();
    reset = 1'b0;
    check("rst.cmd_valid", 64'(cmd_valid), 64'd0);
    repeat (3) begin
      tick();
      check("rst.stays_empty", 64'({cmd_valid, take_action, take_no_action, bad_ir}), 64'd0);
    end
    cmd_ready = 1'b0;
    pulse_uir(2'd2);
    pulse_udr(38'h20_0000_0C0D);
    wait_valid("rst.new_valid");
    check("rst.new_ir", 64'(cmd_ir), 64'd2);
    check("rst.new_jdo", 64'(cmd_jdo), 64'h20_0000_0C0D);
    accept("rst.new", 3'b100, 3'b000, 1'b0);
    $display("reset mid-operation sequence complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
